// File: rtl/mul_share_arbiter_pkg.sv
// Shared FFT datapath constants and types for the twiddle multiplier share arbiter.
// Multiplier and arbiter both take their latency default from here so they stay aligned.
package mul_share_arbiter_pkg;

  // Q15 data path and Q7 coefficient widths
  localparam int unsigned DATA_W = 16;
  localparam int unsigned COEF_W = 8;

  localparam int unsigned MUL_LAT_DEFAULT = 4;
  localparam int unsigned N_REQ_DEFAULT   = 4;
  localparam int unsigned ID_W_DEFAULT    = $clog2(N_REQ_DEFAULT);

  typedef logic [ID_W_DEFAULT-1:0] req_id_t;

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Round-robin priority arbiter: searches from ptr upward with wrap-around and
// returns a one-hot grant plus the granted index.
module mul_share_arbiter_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (en) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) begin
          idx = idx - N;
        end
        if (!found && req[idx[IDX_W-1:0]]) begin
          found                  = 1'b1;
          gnt[idx[IDX_W-1:0]]    = 1'b1;
          gnt_idx                = idx[IDX_W-1:0];
        end
      end
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one fixed-latency Q15 x Q7 multiplier between N_REQ requesters, returning each
// product to its originator via a tag pipeline matched to the multiplier latency.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEFAULT,
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
  parameter int unsigned ID_W    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [DATA_W*N_REQ-1:0]  req_a,
  input  logic [COEF_W*N_REQ-1:0]  req_b,
  output logic [DATA_W-1:0]        mul_a,
  output logic [COEF_W-1:0]        mul_b,
  input  logic [DATA_W-1:0]        mul_p,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  logic             arb_en;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_valid;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic [DATA_W-1:0] sel_a, mul_a_q;
  logic [COEF_W-1:0] sel_b, mul_b_q;
  logic              issue_valid_q;
  logic [ID_W-1:0]   issue_id_q;

  logic [MUL_LAT-1:0] tag_valid_q;
  logic [ID_W-1:0]    tag_id_q [MUL_LAT];
  logic               tail_valid;
  logic [ID_W-1:0]    tail_id;

  logic [N_REQ-1:0]  rsp_valid_d, rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;

  // Keep req_ready low while reset is held so no requester sees a phantom grant.
  assign arb_en = en & ~rst;

  mul_share_arbiter_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_a = req_a[DATA_W*gnt_idx +: DATA_W];
    sel_b = req_b[COEF_W*gnt_idx +: COEF_W];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Idle cycles drive zero operands so the multiplier input is deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
    end else begin
      ptr_q         <= ptr_d;
      mul_a_q       <= gnt_valid ? sel_a : '0;
      mul_b_q       <= gnt_valid ? sel_b : '0;
      issue_valid_q <= gnt_valid;
      issue_id_q    <= gnt_valid ? gnt_idx : '0;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  // The last tag stage lines up with the product presented on mul_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      tag_valid_q[0] <= issue_valid_q;
      tag_id_q[0]    <= issue_id_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_valid_q[k] <= tag_valid_q[k-1];
        tag_id_q[k]    <= tag_id_q[k-1];
      end
    end
  end

  assign tail_valid = tag_valid_q[MUL_LAT-1];
  assign tail_id    = tag_id_q[MUL_LAT-1];

  always_comb begin
    rsp_valid_d = '0;
    if (tail_valid) begin
      rsp_valid_d[tail_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tail_valid) begin
        rsp_data_q <= mul_p;
        rsp_id_q   <= tail_id;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = issue_valid_q | (|tag_valid_q);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with a 4-stage Q15 x Q7 multiplier model.
module tb_mul_share_arbiter;
  import mul_share_arbiter_pkg::*;

  localparam int unsigned N_REQ   = 4;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    en;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W*N_REQ-1:0] req_a;
  logic [COEF_W*N_REQ-1:0] req_b;
  logic [DATA_W-1:0]       mul_a;
  logic [COEF_W-1:0]       mul_b;
  logic [DATA_W-1:0]       mul_p;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .N_REQ   (N_REQ),
    .MUL_LAT (MUL_LAT),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Sign-magnitude Q15 x Q7 -> Q15 multiply with saturation, no reset, fixed latency.
  function automatic logic [15:0] q_mul(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] ma;
    logic [8:0]  mb;
    logic [25:0] prod;
    logic [18:0] mag;
    logic        neg;
    neg  = a[15] ^ b[7];
    ma   = a[15] ? (17'd0 - {a[15], a}) : {1'b0, a};
    mb   = b[7] ? (9'd0 - {b[7], b}) : {1'b0, b};
    prod = 26'(ma) * 26'(mb);
    mag  = prod[25:7];
    if (!neg && mag > 19'h7FFF) return 16'h7FFF;
    if (neg && mag > 19'h8000) return 16'h8000;
    return neg ? 16'(19'd0 - mag) : mag[15:0];
  endfunction

  logic [15:0] mp [MUL_LAT];
  always_ff @(posedge clk) begin
    mp[0] <= q_mul(mul_a, mul_b);
    for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
  end
  assign mul_p = mp[MUL_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [7:0] b);
    req_a[16*i +: 16] = a;
    req_b[8*i +: 8]   = b;
  endtask

  logic [15:0] prod4 [4];

  initial begin
    prod4[0] = 16'h0FE0; prod4[1] = 16'h1FC0; prod4[2] = 16'h2FA0; prod4[3] = 16'h3F80;
    en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    #1 rst = 1'b1;
    repeat (2) next_cycle();
    #1;
    chk("reset_ready", 32'(req_ready), 0);
    chk("reset_mul_a", 32'(mul_a), 0);
    chk("reset_mul_b", 32'(mul_b), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;

    // Single request from requester 1: 0.5 x 0.5
    next_cycle();
    req_valid = 4'b0010; set_op(1, 16'h4000, 8'h40);
    #1 chk("single_ready", 32'(req_ready), 'b0010);
    next_cycle();
    req_valid = '0;
    #1;
    chk("single_mul_a", 32'(mul_a), 'h4000);
    chk("single_mul_b", 32'(mul_b), 'h40);
    chk("single_busy_c1", 32'(busy), 1);
    repeat (4) next_cycle();
    #1;
    chk("single_no_rsp_c5", 32'(rsp_valid), 0);
    chk("single_busy_c5", 32'(busy), 1);
    next_cycle();
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 'b0010);
    chk("single_rsp_data", 32'(rsp_data), 'h2000);
    chk("single_rsp_id", 32'(rsp_id), 1);
    chk("single_busy_c6", 32'(busy), 0);
    next_cycle();
    #1;
    chk("single_strobe_drop", 32'(rsp_valid), 0);
    chk("single_data_hold", 32'(rsp_data), 'h2000);

    // Reset to bring ptr back to 0
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;

    // All four requesting for 8 cycles
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h1000 * (i + 1)), 8'h7F);
    for (int c = 0; c < 14; c++) begin
      next_cycle();
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk("rr_ready", 32'(req_ready), (c < 8) ? (1 << (c % 4)) : 0);
      if (c >= 6) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 1 << ((c - 6) % 4));
        chk("rr_rsp_id", 32'(rsp_id), (c - 6) % 4);
        chk("rr_rsp_data", 32'(rsp_data), 32'(prod4[(c - 6) % 4]));
      end else begin
        chk("rr_no_rsp", 32'(rsp_valid), 0);
      end
      if (c == 12) chk("rr_busy_c12", 32'(busy), 1);
      if (c == 13) chk("rr_busy_c13", 32'(busy), 0);
    end

    // Negative operands on requester 0 (ptr now 0, then 1)
    next_cycle();
    req_valid = 4'b0001; set_op(0, 16'hC000, 8'h40);
    #1 chk("neg_ready_0", 32'(req_ready), 'b0001);
    next_cycle();
    set_op(0, 16'h4000, 8'hC0);
    #1 chk("neg_ready_1", 32'(req_ready), 'b0001);
    next_cycle();
    req_valid = '0;
    #1;
    chk("neg_mul_a", 32'(mul_a), 'h4000);
    chk("neg_mul_b", 32'(mul_b), 'hC0);
    repeat (4) next_cycle();
    #1;
    chk("neg_rsp_valid_0", 32'(rsp_valid), 'b0001);
    chk("neg_rsp_data_0", 32'(rsp_data), 'hE000);
    chk("neg_rsp_id_0", 32'(rsp_id), 0);
    next_cycle();
    #1;
    chk("neg_rsp_valid_1", 32'(rsp_valid), 'b0001);
    chk("neg_rsp_data_1", 32'(rsp_data), 'hE000);
    next_cycle();
    #1;
    chk("neg_drained", 32'(busy), 0);

    // en low for 3 cycles with requesters 2 and 3 waiting
    next_cycle();
    en = 1'b0; req_valid = 4'b1100;
    set_op(2, 16'h2000, 8'h40); set_op(3, 16'h6000, 8'h20);
    #1 chk("en_off_ready_0", 32'(req_ready), 0);
    next_cycle();
    #1;
    chk("en_off_ready_1", 32'(req_ready), 0);
    chk("en_off_mul_a_1", 32'(mul_a), 0);
    next_cycle();
    #1;
    chk("en_off_ready_2", 32'(req_ready), 0);
    chk("en_off_mul_a_2", 32'(mul_a), 0);
    chk("en_off_busy", 32'(busy), 0);
    next_cycle();
    en = 1'b1;
    #1 chk("en_on_ready_2", 32'(req_ready), 'b0100);
    next_cycle();
    #1;
    chk("en_on_ready_3", 32'(req_ready), 'b1000);
    chk("en_on_mul_a_2", 32'(mul_a), 'h2000);
    next_cycle();
    req_valid = '0;
    #1;
    chk("en_on_mul_a_3", 32'(mul_a), 'h6000);
    chk("en_on_mul_b_3", 32'(mul_b), 'h20);
    repeat (4) next_cycle();
    #1;
    chk("en_rsp_valid_2", 32'(rsp_valid), 'b0100);
    chk("en_rsp_id_2", 32'(rsp_id), 2);
    chk("en_rsp_data_2", 32'(rsp_data), 'h1000);
    next_cycle();
    #1;
    chk("en_rsp_valid_3", 32'(rsp_valid), 'b1000);
    chk("en_rsp_id_3", 32'(rsp_id), 3);
    chk("en_rsp_data_3", 32'(rsp_data), 'h1800);
    next_cycle();
    #1 chk("en_drained", 32'(busy), 0);

    // Reset mid-flight after three back-to-back transfers (grants 1,2,3)
    for (int i = 1; i < 4; i++) set_op(i, 16'h1000, 8'h40);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      req_valid = 4'b1110;
      #1 chk("rst_burst_ready", 32'(req_ready), 1 << (c + 1));
    end
    next_cycle();
    req_valid = '0;
    next_cycle();
    #1 chk("rst_busy_before", 32'(busy), 1);
    rst = 1'b1; req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    next_cycle();
    #1 chk("rst_ready_held", 32'(req_ready), 0);
    next_cycle();
    rst = 1'b0; req_valid = 4'b1001; set_op(0, 16'h7FFF, 8'h7F);
    #1 chk("rst_after_ready", 32'(req_ready), 'b0001);
    chk("rst_after_no_rsp_c6", 32'(rsp_valid), 0);
    for (int c = 7; c < 12; c++) begin
      next_cycle();
      req_valid = '0;
      #1 chk("rst_stale_rsp", 32'(rsp_valid), 0);
    end
    next_cycle();
    #1;
    chk("rst_new_rsp_valid", 32'(rsp_valid), 'b0001);
    chk("rst_new_rsp_data", 32'(rsp_data), 'h7EFF);
    chk("rst_new_rsp_id", 32'(rsp_id), 0);

    // Only requester 3 valid, granted every cycle with ptr at 1
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      if (c < 5) begin
        req_valid = 4'b1000;
        set_op(3, 16'(16'h0100 * (c + 1)), 8'h40);
      end else begin
        req_valid = '0;
      end
      #1;
      if (c < 5) chk("solo_ready", 32'(req_ready), 'b1000);
      if (c >= 6) begin
        chk("solo_rsp_valid", 32'(rsp_valid), 'b1000);
        chk("solo_rsp_id", 32'(rsp_id), 3);
        chk("solo_rsp_data", 32'(rsp_data), 'h80 * (c - 5));
      end
    end
    next_cycle();
    #1;
    chk("solo_end_rsp", 32'(rsp_valid), 0);
    chk("solo_end_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
